// File: rtl/mem_arbiter_rr_if.sv
`timescale 1ns/1ps
// Bus bundle for mem_arbiter_rr: per-client miss ports plus the shared memory line port.
// master = the arbiter, slave = the clients and memory that surround it.
interface mem_arbiter_rr_if #(
   parameter int NUM_CLIENTS = 2,
   parameter int ADDR_W      = 32,
   parameter int LINE_W      = 256,
   parameter int IDX_W       = $clog2(NUM_CLIENTS)
);
   logic [NUM_CLIENTS-1:0]        req_read;
   logic [NUM_CLIENTS-1:0]        req_write;
   logic [NUM_CLIENTS*ADDR_W-1:0] req_addr;
   logic [NUM_CLIENTS*LINE_W-1:0] req_wdata;
   logic [NUM_CLIENTS-1:0]        req_resp;
   logic [LINE_W-1:0]             req_rdata;
   logic                          mem_read;
   logic                          mem_write;
   logic [ADDR_W-1:0]             mem_addr;
   logic [LINE_W-1:0]             mem_wdata;
   logic [LINE_W-1:0]             mem_rdata;
   logic                          mem_resp;
   logic                          busy;
   logic [IDX_W-1:0]              grant_idx;

   modport master (
      input  req_read, req_write, req_addr, req_wdata, mem_rdata, mem_resp,
      output req_resp, req_rdata, mem_read, mem_write, mem_addr, mem_wdata, busy, grant_idx
   );

   modport slave (
      output req_read, req_write, req_addr, req_wdata, mem_rdata, mem_resp,
      input  req_resp, req_rdata, mem_read, mem_write, mem_addr, mem_wdata, busy, grant_idx
   );
endinterface

// File: rtl/mem_arbiter_rr.sv
`timescale 1ns/1ps
// N-client cache-line arbiter onto one memory line port, round-robin or fixed priority.
// The winner's op/address/data are latched at grant and driven from registers until mem_resp.
module mem_arbiter_rr #(
   parameter int NUM_CLIENTS = 2,
   parameter int ADDR_W      = 32,
   parameter int LINE_W      = 256,
   parameter int PRIO_MODE   = 0,
   parameter int IDX_W       = $clog2(NUM_CLIENTS)
) (
   input  logic             clk,
   input  logic             rst_n,
   mem_arbiter_rr_if.master bus
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t                 r_state;
   state_t                 w_next_state;
   logic [NUM_CLIENTS-1:0] w_req;
   logic [IDX_W-1:0]       r_rr_ptr;
   logic [IDX_W-1:0]       r_grant_idx;
   logic [IDX_W-1:0]       w_win_idx;
   logic                   w_win_found;
   logic                   r_op_write;
   logic [ADDR_W-1:0]      r_addr;
   logic [ADDR_W-1:0]      w_win_addr;
   logic [LINE_W-1:0]      r_wdata;
   logic [LINE_W-1:0]      w_win_wdata;
   logic [LINE_W-1:0]      r_rdata;

   assign w_req = bus.req_read | bus.req_write;

   // Winner search; later loop iterations are higher priority, so iterate from lowest priority up.
   always_comb begin
      // NOTE: every always_comb output is defaulted first so no path leaves it unassigned (no latch).
      w_win_found = 1'b0;
      w_win_idx   = '0;
      if (PRIO_MODE == 1) begin
         for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            if (w_req[i]) begin
               w_win_found = 1'b1;
               w_win_idx   = IDX_W'(i);
            end
         end
      end else begin
         for (int off = NUM_CLIENTS; off >= 1; off--) begin
            if (w_req[(int'(r_rr_ptr) + off) % NUM_CLIENTS]) begin
               w_win_found = 1'b1;
               w_win_idx   = IDX_W'((int'(r_rr_ptr) + off) % NUM_CLIENTS);
            end
         end
      end
   end

   always_comb begin
      w_win_addr  = bus.req_addr[int'(w_win_idx)*ADDR_W +: ADDR_W];
      w_win_wdata = bus.req_wdata[int'(w_win_idx)*LINE_W +: LINE_W];
   end

   always_comb begin
      w_next_state  = r_state;
      bus.req_resp  = '0;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_win_found) w_next_state = S_BUSY;
         end
         S_BUSY: begin
            bus.mem_read  = ~r_op_write;
            bus.mem_write = r_op_write;
            if (bus.mem_resp) w_next_state = S_DONE;
         end
         S_DONE: begin
            bus.req_resp[r_grant_idx] = 1'b1;
            w_next_state              = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the line-wide data registers are reset as well, so mem_wdata/req_rdata read 0 after reset.
         r_state     <= S_IDLE;
         r_rr_ptr    <= IDX_W'(NUM_CLIENTS - 1);
         r_grant_idx <= '0;
         r_op_write  <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rdata     <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
         r_state <= w_next_state;
         if (r_state == S_IDLE && w_win_found) begin
            r_op_write  <= bus.req_write[w_win_idx];
            r_addr      <= w_win_addr;
            r_wdata     <= w_win_wdata;
            r_grant_idx <= w_win_idx;
            if (PRIO_MODE == 0) r_rr_ptr <= w_win_idx;
         end
         if (r_state == S_BUSY && bus.mem_resp && !r_op_write) r_rdata <= bus.mem_rdata;
      end
   end

   assign bus.busy      = (r_state != S_IDLE);
   assign bus.grant_idx = r_grant_idx;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;
   assign bus.req_rdata = r_rdata;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
`timescale 1ns/1ps
// Directed bench for mem_arbiter_rr: 2-client round-robin, 2-client fixed priority (mirrored
// stimulus) and 4-client round-robin instances, each with a small latency-programmable memory.
module tb_mem_arbiter_rr;
   localparam int AW = 32;
   localparam int LW = 256;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   lat      = 3;
   logic man_rr2  = 1'b0;
   int   cnt_rr2  = 0;
   int   cnt_fp2  = 0;
   int   cnt_rr4  = 0;
   logic [1:0] prev_rr2 = '0;
   logic [1:0] prev_fp2 = '0;
   logic [3:0] prev_rr4 = '0;
   int   q_rr2[$];
   int   q_fp2[$];
   int   exp_rr[5]   = '{0, 1, 0, 1, 1};
   int   exp_fp[5]   = '{0, 0, 0, 0, 1};
   int   exp_c4[3]   = '{1, 2, 3};
   logic exp_wr4[3]  = '{1'b1, 1'b0, 1'b1};
   int   c;

   mem_arbiter_rr_if #(.NUM_CLIENTS(2), .ADDR_W(AW), .LINE_W(LW)) if_rr2 ();
   mem_arbiter_rr_if #(.NUM_CLIENTS(2), .ADDR_W(AW), .LINE_W(LW)) if_fp2 ();
   mem_arbiter_rr_if #(.NUM_CLIENTS(4), .ADDR_W(AW), .LINE_W(LW)) if_rr4 ();

   mem_arbiter_rr #(.NUM_CLIENTS(2), .ADDR_W(AW), .LINE_W(LW), .PRIO_MODE(0)) u_rr2 (
      .clk(clk), .rst_n(rst_n), .bus(if_rr2.master));
   mem_arbiter_rr #(.NUM_CLIENTS(2), .ADDR_W(AW), .LINE_W(LW), .PRIO_MODE(1)) u_fp2 (
      .clk(clk), .rst_n(rst_n), .bus(if_fp2.master));
   mem_arbiter_rr #(.NUM_CLIENTS(4), .ADDR_W(AW), .LINE_W(LW), .PRIO_MODE(0)) u_rr4 (
      .clk(clk), .rst_n(rst_n), .bus(if_rr4.master));

   // Fixed-priority instance sees exactly the client traffic of the 2-client round-robin one.
   assign if_fp2.req_read  = if_rr2.req_read;
   assign if_fp2.req_write = if_rr2.req_write;
   assign if_fp2.req_addr  = if_rr2.req_addr;
   assign if_fp2.req_wdata = if_rr2.req_wdata;
   assign if_fp2.mem_rdata = if_rr2.mem_rdata;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory models: respond in the lat-th cycle of a strobe.
   always @(negedge clk) begin
      cnt_rr2 = (if_rr2.mem_read || if_rr2.mem_write) ? cnt_rr2 + 1 : 0;
      if_rr2.mem_resp = man_rr2 || (cnt_rr2 == lat);
      cnt_fp2 = (if_fp2.mem_read || if_fp2.mem_write) ? cnt_fp2 + 1 : 0;
      if_fp2.mem_resp = (cnt_fp2 == lat);
      cnt_rr4 = (if_rr4.mem_read || if_rr4.mem_write) ? cnt_rr4 + 1 : 0;
      if_rr4.mem_resp = (cnt_rr4 == lat);
   end

   function automatic int idx_of(input logic [3:0] v);
      idx_of = -1;
      for (int i = 0; i < 4; i++) if (v[i]) idx_of = i;
   endfunction

   function automatic logic [LW-1:0] pat(input logic [7:0] b);
      pat = {32{b}};
   endfunction

   task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_resp(input int sel, input string tag);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick();
         seen = (sel == 0) ? |if_rr2.req_resp : |if_rr4.req_resp;
      end
      check(tag, seen, 1'b1);
   endtask

   // Response monitors: one-hot, single-cycle pulses; grant order recorded for the 2-client pair.
   always @(negedge clk) begin
      assert ((if_rr2.req_read & if_rr2.req_write) == '0) else $error("rr2 read+write together");
      assert ((if_rr4.req_read & if_rr4.req_write) == '0) else $error("rr4 read+write together");
      if (|if_rr2.req_resp) begin
         check("rr2_resp_onehot", $onehot(if_rr2.req_resp), 1'b1);
         check("rr2_resp_1cyc", |prev_rr2, 1'b0);
         q_rr2.push_back(idx_of({2'b00, if_rr2.req_resp}));
      end
      if (|if_fp2.req_resp) begin
         check("fp2_resp_onehot", $onehot(if_fp2.req_resp), 1'b1);
         check("fp2_resp_1cyc", |prev_fp2, 1'b0);
         q_fp2.push_back(idx_of({2'b00, if_fp2.req_resp}));
      end
      if (|if_rr4.req_resp) begin
         check("rr4_resp_onehot", $onehot(if_rr4.req_resp), 1'b1);
         check("rr4_resp_1cyc", |prev_rr4, 1'b0);
      end
      prev_rr2 = if_rr2.req_resp;
      prev_fp2 = if_fp2.req_resp;
      prev_rr4 = if_rr4.req_resp;
   end

   initial begin
      rst_n            = 1'b0;
      if_rr2.req_read  = '0;
      if_rr2.req_write = '0;
      if_rr2.req_addr  = '0;
      if_rr2.req_wdata = '0;
      if_rr2.mem_rdata = '0;
      if_rr4.req_read  = '0;
      if_rr4.req_write = '0;
      if_rr4.req_addr  = '0;
      if_rr4.req_wdata = '0;
      if_rr4.mem_rdata = '0;
      repeat (2) tick();

      // Reset state
      check("rst_busy", if_rr2.busy, 1'b0);
      check("rst_resp", if_rr2.req_resp, 2'b00);
      check("rst_strobes", {if_rr2.mem_read, if_rr2.mem_write}, 2'b00);
      check("rst_addr", if_rr2.mem_addr, 32'h0);
      check("rst_wdata", if_rr2.mem_wdata, '0);
      check("rst_rdata", if_rr2.req_rdata, '0);
      check("rst_grant", if_rr2.grant_idx, 1'b0);
      check("rst_rr4", {if_rr4.busy, if_rr4.grant_idx, if_rr4.mem_read, if_rr4.mem_write}, 5'b0);
      rst_n = 1'b1;
      tick();
      check("idle_no_req", if_rr2.busy, 1'b0);

      // Single read from client 0, memory answers in the 3rd busy cycle
      lat = 3;
      if_rr2.req_read  = 2'b01;
      if_rr2.req_addr  = {32'h0, 32'h0000_1000};
      if_rr2.mem_rdata = pat(8'hA5);
      tick();
      check("rd_t1_read", {if_rr2.mem_read, if_rr2.mem_write}, 2'b10);
      check("rd_t1_addr", if_rr2.mem_addr, 32'h0000_1000);
      check("rd_t1_busy", if_rr2.busy, 1'b1);
      check("rd_t1_grant", if_rr2.grant_idx, 1'b0);
      tick();
      check("rd_t2_read", if_rr2.mem_read, 1'b1);
      tick();
      check("rd_t3_read", if_rr2.mem_read, 1'b1);
      check("rd_t3_noresp", if_rr2.req_resp, 2'b00);
      tick();
      check("rd_t4_resp", if_rr2.req_resp, 2'b01);
      check("rd_t4_rdata", if_rr2.req_rdata, pat(8'hA5));
      check("rd_t4_read_low", if_rr2.mem_read, 1'b0);
      check("rd_t4_busy", if_rr2.busy, 1'b1);
      if_rr2.req_read = 2'b00;
      tick();
      check("rd_t5_busy", if_rr2.busy, 1'b0);
      check("rd_t5_resp", if_rr2.req_resp, 2'b00);
      check("rd_t5_grant_held", if_rr2.grant_idx, 1'b0);

      // Reset mid-BUSY, then a fresh request from client 1
      if_rr2.req_read = 2'b01;
      if_rr2.req_addr = {32'h0, 32'h0000_2000};
      tick();
      check("mid_read_before", if_rr2.mem_read, 1'b1);
      rst_n = 1'b0;
      if_rr2.req_read = 2'b00;
      #1;
      check("mid_async_read", if_rr2.mem_read, 1'b0);
      check("mid_async_busy", if_rr2.busy, 1'b0);
      check("mid_async_addr", if_rr2.mem_addr, 32'h0);
      check("mid_async_rdata", if_rr2.req_rdata, '0);
      tick();
      rst_n = 1'b1;
      if_rr2.req_read = 2'b10;
      if_rr2.req_addr = {32'h0000_3000, 32'h0};
      tick();
      check("post_rst_grant", if_rr2.grant_idx, 1'b1);
      check("post_rst_addr", if_rr2.mem_addr, 32'h0000_3000);
      check("post_rst_read", if_rr2.mem_read, 1'b1);
      wait_resp(0, "post_rst_resp_seen");
      check("post_rst_resp", if_rr2.req_resp, 2'b10);
      if_rr2.req_read = 2'b00;
      tick();

      // Continuous contention: round-robin alternates, fixed priority keeps client 0
      lat = 2;
      q_rr2.delete();
      q_fp2.delete();
      if_rr2.req_addr = {32'h0000_7100, 32'h0000_7000};
      if_rr2.req_read = 2'b11;
      for (int n = 0; n < 4; n++) wait_resp(0, "cont_resp_seen");
      if_rr2.req_read = 2'b10;
      wait_resp(0, "cont_last_seen");
      if_rr2.req_read = 2'b00;
      tick();
      check("cont_rr_count", q_rr2.size(), 5);
      check("cont_fp_count", q_fp2.size(), 5);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("cont_rr_grant%0d", i), (i < q_rr2.size()) ? q_rr2[i] : -1, exp_rr[i]);
         check($sformatf("cont_fp_grant%0d", i), (i < q_fp2.size()) ? q_fp2[i] : -1, exp_fp[i]);
      end

      // 4 clients: 1 and 3 write, 2 reads; inputs of the granted client change during BUSY
      if_rr4.req_write = 4'b1010;
      if_rr4.req_read  = 4'b0100;
      if_rr4.req_addr  = {32'h0000_4300, 32'h0000_4200, 32'h0000_4100, 32'h0000_4000};
      if_rr4.req_wdata = {pat(8'h33), pat(8'h22), pat(8'h11), pat(8'h00)};
      if_rr4.mem_rdata = pat(8'hC3);
      for (int k = 0; k < 3; k++) begin
         c = exp_c4[k];
         tick();
         check($sformatf("rr4_grant%0d", k), if_rr4.grant_idx, c);
         check($sformatf("rr4_op%0d", k), {if_rr4.mem_write, if_rr4.mem_read},
               {exp_wr4[k], ~exp_wr4[k]});
         check($sformatf("rr4_addr%0d", k), if_rr4.mem_addr, 32'h0000_4000 + 32'h100 * c);
         check($sformatf("rr4_wdata%0d", k), if_rr4.mem_wdata, pat(8'(8'h11 * c)));
         if_rr4.req_addr[c*AW +: AW]  = 32'hBAD0_0000;
         if_rr4.req_wdata[c*LW +: LW] = pat(8'hEE);
         if (c == 3) if_rr4.mem_rdata = pat(8'hDD);
         tick();
         check($sformatf("rr4_addr_hold%0d", k), if_rr4.mem_addr, 32'h0000_4000 + 32'h100 * c);
         check($sformatf("rr4_wdata_hold%0d", k), if_rr4.mem_wdata, pat(8'(8'h11 * c)));
         wait_resp(1, "rr4_resp_seen");
         check($sformatf("rr4_resp%0d", k), if_rr4.req_resp, 4'b0001 << c);
         check($sformatf("rr4_rdata%0d", k), if_rr4.req_rdata, (c == 1) ? '0 : pat(8'hC3));
         if_rr4.req_read[c]  = 1'b0;
         if_rr4.req_write[c] = 1'b0;
         tick();
      end
      check("rr4_idle_end", if_rr4.busy, 1'b0);

      // 0-wait memory and spurious mem_resp pulses in IDLE and DONE
      lat = 1;
      man_rr2 = 1'b1;
      tick();
      man_rr2 = 1'b0;
      check("spur_idle_busy", if_rr2.busy, 1'b0);
      check("spur_idle_resp", if_rr2.req_resp, 2'b00);
      tick();
      check("spur_idle_resp2", {if_rr2.busy, if_rr2.req_resp}, 3'b000);
      if_rr2.req_read  = 2'b01;
      if_rr2.req_addr  = {32'h0, 32'h0000_5000};
      if_rr2.mem_rdata = pat(8'h5A);
      tick();
      check("zw_t1_read", {if_rr2.busy, if_rr2.mem_read}, 2'b11);
      check("zw_t1_addr", if_rr2.mem_addr, 32'h0000_5000);
      tick();
      check("zw_t2_resp", if_rr2.req_resp, 2'b01);
      check("zw_t2_rdata", if_rr2.req_rdata, pat(8'h5A));
      if_rr2.req_read = 2'b00;
      man_rr2 = 1'b1;
      tick();
      man_rr2 = 1'b0;
      check("zw_t3_idle", if_rr2.busy, 1'b0);
      check("zw_t3_resp", if_rr2.req_resp, 2'b00);
      tick();
      check("zw_t4_idle", {if_rr2.busy, if_rr2.req_resp}, 3'b000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- N-client arbiter between per-client cache-line miss ports (I-cache, D-cache, prefetcher, …) and one shared physical-memory/L2 line port.
- Priority mode is selectable: round-robin or fixed.
- At grant, the arbiter latches the winner's op, address and write data, and drives them to memory from registers until memory responds.
- Read data and the client response are registered, so no client-side combinational path reaches the memory port.

Parameters:
- NUM_CLIENTS, 2, number of requesting ports (>=2).
- ADDR_W, 32, address width.
- LINE_W, 256, line width in bits.
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (index 0 highest; the D-cache is wired to index 0).
- IDX_W, $clog2(NUM_CLIENTS), grant index width (derived).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- req_read  in  NUM_CLIENTS  per-client line read request (level, held until resp)
- req_write  in  NUM_CLIENTS  per-client line write request (level, held until resp)
- req_addr  in  NUM_CLIENTS*ADDR_W  packed; client i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_CLIENTS*LINE_W  packed; client i at [i*LINE_W +: LINE_W]
- req_resp  out  NUM_CLIENTS  one-hot, 1-cycle completion pulse
- req_rdata  out  LINE_W  shared registered read data, valid when any req_resp bit is high
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  LINE_W  latched write data
- mem_rdata  in  LINE_W  memory read data
- mem_resp  in  1  memory completion, 1 cycle
- busy  out  1  high in BUSY or DONE
- grant_idx  out  IDX_W  index of the current/last granted client

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - req_resp, mem_read, mem_write, busy = 0.
  - mem_addr, mem_wdata, req_rdata, grant_idx = 0.
  - rr_ptr = NUM_CLIENTS-1, so client 0 wins the first round-robin arbitration.
  - Reset mid-transaction aborts it immediately; the memory side is reset by the same rst_n.
- Request vector: req_i = req_read[i] | req_write[i]. If both bits are high for one client, it is treated as a write (illegal; assertion in the bench).
- IDLE:
  - If any req_i is high, select a winner w:
    - PRIO_MODE=0: first set bit searching rr_ptr+1, rr_ptr+2, … with wrap modulo NUM_CLIENTS.
    - PRIO_MODE=1: lowest set index.
  - On the clock edge: latch op (write if req_write[w]), mem_addr<=req_addr[w], mem_wdata<=req_wdata[w], grant_idx<=w; rr_ptr<=w (mode 0 only); go to BUSY.
  - With no request, stay in IDLE; all outputs stay low.
- BUSY:
  - mem_read = latched op is read; mem_write = latched op is write. Exactly one is high.
  - Address and data stay stable for the whole state; later changes on client inputs are ignored.
  - On mem_resp=1: req_rdata<=mem_rdata (reads only; writes leave req_rdata unchanged); go to DONE.
  - mem_read/mem_write are low from the next cycle.
- DONE:
  - req_resp[grant_idx]=1 for exactly one cycle; all other bits 0. Go to IDLE.
- Latency:
  - Request first seen in IDLE at cycle t gives mem_read/mem_write high at t+1.
  - mem_resp at cycle k gives req_resp at k+1; IDLE at k+2, where the next arbitration happens.
  - Minimum turnaround is mem latency + 2 cycles.
- Client rule: deassert the request on the clock edge that ends the req_resp cycle. A request still high in the IDLE cycle after its own resp is treated as a new request.
- Ordering:
  - Requests arriving while BUSY/DONE wait; they are not queued beyond the level signal.
  - Round-robin bounds wait to NUM_CLIENTS-1 transactions per client.
  - Fixed mode may starve high indices; this is accepted.
- mem_resp outside BUSY is ignored (no state change, no req_resp).
- mem_resp on the first BUSY cycle (0-wait memory) is legal.
- busy = (state != IDLE). grant_idx holds its value after completion until the next grant.

Test Plan:
- Reset mid-BUSY (read in flight, rst_n low for 1 cycle) -> mem_read drops asynchronously, all outputs 0, state IDLE; the next single request from client 1 is granted normally.
- NUM_CLIENTS=2, PRIO_MODE=0, client 0 reads addr 0x0000_1000 alone, memory responds after 3 cycles with 0xA5..A5 -> mem_read high cycles t+1..t+3; mem_addr=0x1000; req_resp=2'b01 at t+4; req_rdata=0xA5..A5; busy low at t+5.
- Clients 0 and 1 both request continuously, PRIO_MODE=0 -> grant order 0,1,0,1; each req_resp is one-hot and one cycle.
- Same stimulus, PRIO_MODE=1 -> client 0 granted every time; client 1 only after client 0 deasserts.
- NUM_CLIENTS=4, round-robin, clients 1 and 3 write while client 2 reads -> grant order 1,2,3. Each mem_wdata matches its client's latched req_wdata, even when client inputs change during BUSY.
- 0-wait memory (mem_resp on the first BUSY cycle) plus a spurious mem_resp pulse in IDLE -> completion in 3 cycles total; the spurious pulse causes no req_resp and no state change.
